// File: rtl/csi_tx_packetizer.sv
// csi_tx_packetizer: CSI-2 transmit packet builder (sync, header+ECC, payload, CRC-16, gap) onto NUM_LANE lane bytes

// csi_rx_hdr_ecc: CSI-2 packet header ECC over {WC, DI}; the top two parity bits are always zero
module csi_rx_hdr_ecc (
  input  logic [23:0] data,
  output logic [7:0]  ecc
);
  assign ecc = {2'b00,
                ^{data[23:21], data[19:10]},
                ^{data[23:22], data[20:16], data[9:4]},
                ^{data[23], data[21:19], data[15:13], data[9:7], data[3:1]},
                ^{data[22:20], data[18], data[15], data[12:11], data[9], data[6:5], data[3:2], data[0]},
                ^{data[23:20], data[17], data[14], data[12], data[10], data[8], data[6], data[4:3], data[1:0]},
                ^{data[23:20], data[16], data[13], data[11:10], data[7], data[5:4], data[2:0]}};
endmodule

module csi_tx_packetizer #(
  parameter int NUM_LANE   = 2,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WC     = 8192
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pkt_req,
  output logic                  pkt_ack,
  input  logic [5:0]            pkt_dt,
  input  logic [1:0]            pkt_vc,
  input  logic [15:0]           pkt_wc,
  input  logic [NUM_LANE*8-1:0] payload_in,
  input  logic                  payload_valid,
  output logic                  payload_ready,
  output logic [NUM_LANE*8-1:0] data_out,
  output logic [NUM_LANE-1:0]   byte_en,
  output logic                  hs_active,
  output logic                  pkt_done,
  output logic [1:0]            err_flags
);
  localparam int W = NUM_LANE * 8;
  localparam int LS = $clog2(NUM_LANE);
  localparam logic [15:0] MAX_W = 16'(MAX_WC);
  localparam logic [15:0] LANE_LSB = 16'(NUM_LANE - 1);
  localparam logic [15:0] HDR_LAST = 16'(4 / NUM_LANE - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [NUM_LANE-1:0] BE_CRC = NUM_LANE'(3);

  typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, CRC, GAP} state_t;

  state_t state, state_nxt;
  logic [15:0] cnt, wc_r, wc_adj, crc, crc_nxt;
  logic [5:0] dt_r;
  logic [1:0] vc_r;
  logic long_r, long_req, wc_bad, hdr_last, pay_last, gap_last;
  logic [7:0] ecc;
  logic [31:0] hdr;
  logic [W-1:0] hdr_word, pay_word;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 16'h8408 : 16'h0000);
    return r;
  endfunction

  assign pkt_ack = state == IDLE;
  assign payload_ready = state == PAYLOAD;
  assign long_req = pkt_dt > 6'h0F;
  // Long packets get a lane-aligned, capped byte count; short packets carry WC as raw data
  assign wc_adj = !long_req ? pkt_wc : pkt_wc > MAX_W ? MAX_W : pkt_wc & ~LANE_LSB;
  assign wc_bad = long_req && (pkt_wc > MAX_W || |(pkt_wc & LANE_LSB));
  assign hdr_last = cnt == HDR_LAST;
  assign pay_last = cnt == (wc_r >> LS) - 16'd1;
  assign gap_last = cnt == GAP_LAST;
  assign hdr = {ecc, wc_r, vc_r, dt_r};
  assign hdr_word = cnt[0] ? hdr[31:32-W] : hdr[W-1:0];
  assign pay_word = payload_valid ? payload_in : '0;

  csi_rx_hdr_ecc u_ecc (
    .data ({wc_r, vc_r, dt_r}),
    .ecc  (ecc)
  );

  // CRC advance over one payload beat, lane 0 first
  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < NUM_LANE; i++) crc_nxt = crc_byte(crc_nxt, pay_word[8*i +: 8]);
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = pkt_req ? SYNC : IDLE;
      SYNC:    state_nxt = HDR;
      HDR:     state_nxt = !hdr_last ? HDR : !long_r ? GAP : wc_r == 16'd0 ? CRC : PAYLOAD;
      PAYLOAD: state_nxt = pay_last ? CRC : PAYLOAD;
      CRC:     state_nxt = GAP;
      GAP:     state_nxt = gap_last ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // State, per-state cycle counter and latched request fields
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      dt_r <= '0;
      vc_r <= '0;
      wc_r <= '0;
      long_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt != state ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && pkt_req) begin
        dt_r <= pkt_dt;
        vc_r <= pkt_vc;
        wc_r <= wc_adj;
        long_r <= long_req;
      end
    end
  end

  // Registered lane outputs, running CRC and sticky error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      byte_en <= '0;
      hs_active <= 1'b0;
      pkt_done <= 1'b0;
      err_flags <= '0;
      crc <= '0;
    end else begin
      data_out <= state == SYNC ? {NUM_LANE{8'hB8}} : state == HDR ? hdr_word :
                  state == PAYLOAD ? pay_word : state == CRC ? W'(crc) : '0;
      byte_en <= state == CRC ? BE_CRC : state inside {SYNC, HDR, PAYLOAD} ? '1 : '0;
      hs_active <= state inside {SYNC, HDR, PAYLOAD, CRC};
      pkt_done <= state == CRC || (state == HDR && hdr_last && !long_r);
      crc <= state == SYNC ? 16'hFFFF : state == PAYLOAD ? crc_nxt : crc;
      err_flags[0] <= err_flags[0] | (state == PAYLOAD && !payload_valid);
      err_flags[1] <= err_flags[1] | (state == IDLE && pkt_req && wc_bad);
    end
  end
endmodule

// File: tb/tb_csi_tx_packetizer.sv
// tb_csi_tx_packetizer: scoreboard bench for 2-lane and 4-lane packetizers
module tb_csi_tx_packetizer;
  localparam int GAP = 4;
  localparam logic [5:0][23:0] ECC_M = {24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7};
  localparam logic [191:0] SPEC_PAY = 192'hFF0000001EF01EC74F8278C582E08C70D23C78E9FF000001;

  typedef struct packed { logic [31:0] d; logic [3:0] be; logic done; } beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic req2 = 0, pv2 = 0, ack2, rdy2, hs_act2, done2;
  logic [5:0] dt2 = 0;
  logic [1:0] vc2 = 0, be2, err2;
  logic [15:0] wc2 = 0, pin2 = 0, dout2;
  logic req4 = 0, pv4 = 0, ack4, rdy4, hs_act4, done4;
  logic [5:0] dt4 = 0;
  logic [1:0] vc4 = 0, err4;
  logic [3:0] be4;
  logic [15:0] wc4 = 0;
  logic [31:0] pin4 = 0, dout4;

  beat_t exp2[$], exp4[$];
  beat_t eb2, eb4;
  logic [7:0] pay [0:255];
  int bad_beat = -1, beat2 = 0, beat4 = 0, hs2 = 0, hs4 = 0, exp_len = 0;
  int n_chk = 0, n_pass = 0;
  logic mon_en = 1'b1;
  logic [31:0] lst2 = 0, lst4 = 0;

  csi_tx_packetizer #(.NUM_LANE(2), .GAP_CYCLES(GAP), .MAX_WC(8192)) dut2 (
    .clock(clock), .reset_n(reset_n), .pkt_req(req2), .pkt_ack(ack2), .pkt_dt(dt2), .pkt_vc(vc2),
    .pkt_wc(wc2), .payload_in(pin2), .payload_valid(pv2), .payload_ready(rdy2), .data_out(dout2),
    .byte_en(be2), .hs_active(hs_act2), .pkt_done(done2), .err_flags(err2));

  csi_tx_packetizer #(.NUM_LANE(4), .GAP_CYCLES(GAP), .MAX_WC(8192)) dut4 (
    .clock(clock), .reset_n(reset_n), .pkt_req(req4), .pkt_ack(ack4), .pkt_dt(dt4), .pkt_vc(vc4),
    .pkt_wc(wc4), .payload_in(pin4), .payload_valid(pv4), .payload_ready(rdy4), .data_out(dout4),
    .byte_en(be4), .hs_active(hs_act4), .pkt_done(done4), .err_flags(err4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [7:0] ecc_m(input logic [23:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 6; i++) r[i] = ^(d & ECC_M[i]);
    return r;
  endfunction

  function automatic logic [15:0] crc_m(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] be, input logic done);
    return {d, be, done};
  endfunction

  task automatic push_exp(input int nl, input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc, input int bad);
    logic lng;
    logic [15:0] wca, crc;
    logic [7:0] h0, h1, h2, h3, bt;
    logic [31:0] w;
    logic [3:0] all;
    beat_t q[$];
    lng = dt > 6'h0F;
    wca = !lng ? wc : (wc > 16'd8192) ? 16'd8192 : wc - 16'(wc % nl);
    h0 = {vc, dt};
    h1 = wca[7:0];
    h2 = wca[15:8];
    h3 = ecc_m({wca, h0});
    all = nl == 2 ? 4'h3 : 4'hF;
    q.push_back(mk(nl == 2 ? 32'h0000B8B8 : 32'hB8B8B8B8, all, 1'b0));
    if (nl == 2) begin
      q.push_back(mk({16'h0, h1, h0}, all, 1'b0));
      q.push_back(mk({16'h0, h3, h2}, all, !lng));
    end else q.push_back(mk({h3, h2, h1, h0}, all, !lng));
    exp_len = 1 + 4 / nl;
    if (lng) begin
      crc = 16'hFFFF;
      for (int k = 0; k < wca / nl; k++) begin
        w = 0;
        for (int i = 0; i < nl; i++) begin
          bt = (k == bad) ? 8'h00 : pay[k*nl+i];
          w[8*i +: 8] = bt;
          crc = crc_m(crc, bt);
        end
        q.push_back(mk(w, all, 1'b0));
      end
      q.push_back(mk({16'h0, crc}, 4'h3, 1'b1));
      exp_len += wca / nl + 1;
    end
    for (int i = 0; i < q.size(); i++) begin
      if (nl == 2) exp2.push_back(q[i]);
      else exp4.push_back(q[i]);
    end
  endtask

  always @(negedge clock) begin
    if (rdy2) begin
      for (int i = 0; i < 2; i++) pin2[8*i +: 8] = pay[beat2*2+i];
      pv2 = beat2 != bad_beat;
      beat2++;
    end else pv2 = 1'b0;
  end

  always @(negedge clock) begin
    if (rdy4) begin
      for (int i = 0; i < 4; i++) pin4[8*i +: 8] = pay[beat4*4+i];
      pv4 = beat4 != bad_beat;
      beat4++;
    end else pv4 = 1'b0;
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (hs_act2) begin
        hs2++;
        if (exp2.size() == 0) check("extra_beat2", 32'(exp2.size()), 32'd1);
        else begin
          eb2 = exp2.pop_front();
          check("data2", 32'(dout2), eb2.d);
          check("be2", 32'(be2), 32'(eb2.be));
          check("done2", 32'(done2), 32'(eb2.done));
          if (done2) lst2 = 32'(dout2);
        end
      end else check("idle2", 32'({dout2, be2, done2}), 32'd0);
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (hs_act4) begin
        hs4++;
        if (exp4.size() == 0) check("extra_beat4", 32'(exp4.size()), 32'd1);
        else begin
          eb4 = exp4.pop_front();
          check("data4", dout4, eb4.d);
          check("be4", 32'(be4), 32'(eb4.be));
          check("done4", 32'(done4), 32'(eb4.done));
          if (done4) lst4 = dout4;
        end
      end else check("idle4", {dout4[26:0], be4, done4}, 32'd0);
    end
  end

  task automatic wait_idle(input int nl);
    int k;
    k = 0;
    while (!(nl == 2 ? ack2 : ack4) && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("ack_ready", 32'(nl == 2 ? ack2 : ack4), 32'd1);
  endtask

  task automatic wait_done(input int nl);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(nl == 2 ? done2 : done4) && k < 300);
    check("done_seen", 32'(nl == 2 ? done2 : done4), 32'd1);
    @(negedge clock);
    check("queue_drained", 32'(nl == 2 ? exp2.size() : exp4.size()), 32'd0);
    check("hs_len", 32'(nl == 2 ? hs2 : hs4), 32'(exp_len));
  endtask

  task automatic send(input int nl, input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc, input int bad);
    wait_idle(nl);
    push_exp(nl, dt, vc, wc, bad);
    bad_beat = bad;
    @(negedge clock);
    if (nl == 2) begin
      beat2 = 0; hs2 = 0; dt2 = dt; vc2 = vc; wc2 = wc; req2 = 1'b1;
    end else begin
      beat4 = 0; hs4 = 0; dt4 = dt; vc4 = vc; wc4 = wc; req4 = 1'b1;
    end
    @(negedge clock);
    req2 = 1'b0;
    req4 = 1'b0;
    wait_done(nl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, lowc;
    for (int i = 0; i < 256; i++) pay[i] = i < 24 ? SPEC_PAY[191-8*i -: 8] : 8'($urandom);
    repeat (3) @(negedge clock);
    check("rst_ack", 32'(ack2), 32'd1);
    check("rst_out2", 32'({dout2, be2, hs_act2, done2, err2, rdy2}), 32'd0);
    check("rst_out4", {dout4[23:0], be4, hs_act4, done4, err4}, 32'd0);
    reset_n = 1'b1;

    send(2, 6'h00, 2'd0, 16'h0001, -1);
    check("short_ecc", lst2, 32'h00001A00);
    check("short_err", 32'(err2), 32'd0);

    send(2, 6'h2B, 2'd0, 16'd24, -1);
    check("crc24", lst2, 32'h0000E569);
    check("len24", 32'(hs2), 32'd16);

    send(4, 6'h2B, 2'd0, 16'd24, -1);
    check("crc24_x4", lst4, 32'h0000E569);
    check("len24_x4", 32'(hs4), 32'd9);
    check("err_x4", 32'(err4), 32'd0);

    send(2, 6'h2B, 2'd1, 16'd24, 4);
    check("underrun_err", 32'(err2), 32'd1);

    send(2, 6'h2C, 2'd0, 16'd25, -1);
    check("wc25_err", 32'(err2), 32'd3);
    check("wc25_len", 32'(hs2), 32'd16);

    send(4, 6'h2B, 2'd2, 16'd26, -1);
    check("wc26_err_x4", 32'(err4), 32'd2);

    send(2, 6'h2B, 2'd3, 16'd0, -1);
    check("wc0_crc", lst2, 32'h0000FFFF);
    check("wc0_len", 32'(hs2), 32'd4);

    wait_idle(2);
    push_exp(2, 6'h05, 2'd2, 16'hBEEF, -1);
    push_exp(2, 6'h05, 2'd2, 16'hBEEF, -1);
    @(negedge clock);
    hs2 = 0; dt2 = 6'h05; vc2 = 2'd2; wc2 = 16'hBEEF; req2 = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!done2 && k < 100);
    check("b2b_first_done", 32'(done2), 32'd1);
    lowc = 0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (!hs_act2) lowc++;
    end while (!hs_act2 && k < 100);
    check("b2b_gap", 32'(lowc), 32'(GAP + 1));
    req2 = 1'b0;
    exp_len = 6;
    wait_done(2);

    wait_idle(2);
    mon_en = 1'b0;
    bad_beat = -1;
    @(negedge clock);
    beat2 = 0; dt2 = 6'h2B; vc2 = 2'd0; wc2 = 16'd24; req2 = 1'b1;
    @(negedge clock);
    req2 = 1'b0;
    k = 0;
    while (!rdy2 && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("abort_in_payload", 32'(rdy2), 32'd1);
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("abort_out", 32'({dout2, be2, hs_act2, done2, err2}), 32'd0);
    check("abort_ack", 32'(ack2), 32'd1);
    exp2.delete();
    mon_en = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send(2, 6'h2A, 2'd2, 16'd8, -1);
    check("post_reset_err", 32'(err2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/csi_tx_packetizer.md
Name: csi_tx_packetizer

Overview:
- MIPI CSI-2 transmit-side packet builder; mirrors the receive depacketiser.
- Takes packet requests (data type, virtual channel, word count) plus a payload word stream.
- Emits an HS lane-byte stream per packet: per-lane sync byte, 32-bit header with ECC, payload, CRC-16, then inter-packet gap.
- Sits between the test-pattern/ISP source and the per-lane serialisers; loops back into the csi_rx chain for self-test.

Parameters:
- NUM_LANE, 2, lanes driven; legal values 2 and 4; lane_data_t width = NUM_LANE*8.
- GAP_CYCLES, 4, minimum cycles with hs_active low between packets; legal range 1..255.
- MAX_WC, 8192, largest legal long-packet word count in bytes.

Ports:
- clock  in  1  state machine clock.
- reset_n  in  1  asynchronous active-low reset.
- pkt_req  in  1  packet request; fields below are sampled when pkt_req & pkt_ack.
- pkt_ack  out  1  combinational, = (state==IDLE).
- pkt_dt  in  6  data type; DT > 0x0F is a long packet.
- pkt_vc  in  2  virtual channel.
- pkt_wc  in  16  long packet: byte count; short packet: 16-bit data field.
- payload_in  in  NUM_LANE*8  payload bytes; lane i = bits [8i+7:8i], lane 0 is the earliest byte.
- payload_valid  in  1  payload_in valid.
- payload_ready  out  1  = (state==PAYLOAD); consumes one word per cycle.
- data_out  out  NUM_LANE*8  lane bytes to serialisers.
- byte_en  out  NUM_LANE  per-lane byte valid.
- hs_active  out  1  HS burst in progress (SYNC through CRC).
- pkt_done  out  1  one-cycle pulse on the last HS cycle of a packet.
- err_flags  out  2  sticky: [0] payload underrun, [1] illegal WC; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; data_out=0, byte_en=0, hs_active=0, pkt_done=0, err_flags=0, internal counters/CRC cleared.
- Reset mid-packet aborts immediately. No partial CRC is emitted.
- States: IDLE, SYNC, HDR, PAYLOAD, CRC, GAP. All outputs except pkt_ack and payload_ready are registered.
- IDLE:
  - On pkt_req, latch dt, vc and wc. Go to SYNC next cycle.
  - Header DI = {vc, dt}.
- SYNC (1 cycle): every lane = 0xB8; byte_en all 1; hs_active=1.
- HDR: header bytes, in order: DI, WC[7:0], WC[15:8], ECC.
  - ECC = csi_rx_hdr_ecc({WC, DI}) (instantiate that module).
  - NUM_LANE=2: 2 cycles (DI/WC_lo, then WC_hi/ECC). NUM_LANE=4: 1 cycle.
  - Short packet: go to GAP after HDR; pkt_done pulses on the final HDR cycle.
- WC legality (long packets only):
  - If WC % NUM_LANE != 0, or WC > MAX_WC: set err_flags[1].
  - For the non-multiple case, force WC low bits to 0. For WC > MAX_WC, use MAX_WC.
  - The adjusted WC is used in the header, in the ECC and in the beat count.
- PAYLOAD: WC/NUM_LANE cycles.
  - data_out = payload_in when payload_valid=1.
  - Otherwise data_out = 0 and err_flags[0] set. The stream is never stalled; the CRC covers the bytes actually sent.
  - WC=0: skip PAYLOAD entirely.
- CRC: CSI-2 CRC-16, poly x^16+x^12+x^5+1, processed LSB-first (reflected 0x8408).
  - Init 0xFFFF at SYNC; no final XOR; covers payload bytes only, lane 0 first within each beat.
  - NUM_LANE=2: 1 cycle, lanes = {CRC[15:8], CRC[7:0]}, byte_en=2'b11.
  - NUM_LANE=4: 1 cycle, lanes 0/1 = CRC lo/hi, lanes 2/3 = 0x00, byte_en=4'b0011.
  - pkt_done pulses in this cycle.
- GAP: hs_active=0, data_out=0, byte_en=0 for GAP_CYCLES cycles, then IDLE.
- pkt_req is ignored outside IDLE. Back-to-back requests give exactly GAP_CYCLES low cycles plus 1 IDLE cycle between bursts.
- Packet length in cycles:
  - Long packet: 1 + 4/NUM_LANE + WC/NUM_LANE + 1.
  - Short packet: 1 + 4/NUM_LANE.

Test Plan:
- Short packet (NUM_LANE=2): DT=0x00, VC=0, WC=0x0001 → 0xB8B8, then {0x01,0x00}, then {ECC,0x00}. ECC matches csi_rx_hdr_ecc; pkt_done on cycle 3; hs_active low 4 cycles; looped into csi_rx gives in_frame=1.
- Long packet: DT=0x2B, WC=24, payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 → 12 payload beats, then CRC beat lane0=0x69, lane1=0xE5. Total 16 HS cycles.
- Same payload with NUM_LANE=4 → 1 HDR cycle, 6 payload beats, CRC beat {00,00,E5,69}, byte_en=4'b0011.
- payload_valid low on beat 5 of the WC=24 packet → lanes 0x00 that beat; err_flags[0]=1; CRC computed over the zeros; packet length unchanged.
- WC=25 (2-lane) → header WC=24, err_flags[1]=1, 12 payload beats. WC=0 long → header, then CRC beat 0xFFFF.
- reset_n low during PAYLOAD → all outputs 0 asynchronously. After release: IDLE, pkt_ack=1, and the next packet is correct from SYNC.
